interrupt_controller: RTL
=========================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter N_IRQ, default 32, meaning the number of interrupt lines (legal range 2..32; lines above N_IRQ-1 are absent).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, the asynchronous active-high reset.
REQ-004 SHALL have port int_req_i, input, N_IRQ, level interrupt requests from peripherals, one bit per line.
REQ-005 SHALL have port mie_i, input, 32, the interrupt-enable mask from the CSR unit; bit k enables line k.
REQ-006 SHALL have port int_rst_i, input, 1, a one-cycle pulse from the core on mret, meaning the handler is finished.
REQ-007 SHALL have port int_o, output, 1, the interrupt request to the core (trap entry, mepc/mcause capture).
REQ-008 SHALL have port mcause_o, output, 32, the trap cause for the CSR unit's mcause write.
REQ-009 SHALL have port int_fin_o, output, N_IRQ, a one-hot one-cycle completion acknowledge to the serviced peripheral.

Function
REQ-010 SHALL keep a pending register: pending_next = (pending & ~clr) | int_req_i, where clr is the one-hot of the line completed this cycle; set wins over clear.
REQ-011 SHALL treat line k as eligible when pending[k] & mie_i[k].
REQ-012 SHALL implement FSM states IDLE, SCAN, BUSY.
REQ-013 IDLE -> SCAN when any line is eligible; otherwise stay in IDLE.
REQ-014 SCAN: 5-bit pointer ptr tests line ptr each cycle; if eligible -> BUSY, else ptr increments, wrapping N_IRQ-1 -> 0.
REQ-015 SCAN -> IDLE when no line is eligible (mask cleared or pending gone mid-scan); ptr holds.
REQ-016 On SCAN -> BUSY, SHALL register id = ptr and mcause_o = 32'h8000_0000 | id.
REQ-017 int_o SHALL be 1 exactly while in BUSY; mcause_o SHALL hold its last value outside BUSY.
REQ-018 BUSY: on int_rst_i, int_fin_o[id] = 1 for that cycle, clr = one-hot(id), ptr = id+1 with wrap (round-robin), next state IDLE.
REQ-019 int_rst_i SHALL be ignored in IDLE and SCAN; mie_i changes in BUSY SHALL NOT withdraw int_o.
REQ-020 Worst-case latency from eligibility to int_o: 1 (pending register) + 1 (IDLE) + N_IRQ scan cycles.
REQ-021 int_fin_o SHALL be zero in every cycle except the completion cycle.

Reset
REQ-022 rst_i SHALL force state = IDLE, ptr = 0, id = 0, pending = 0, int_o = 0, mcause_o = 0, int_fin_o = 0 immediately, including mid-SCAN or mid-BUSY.
REQ-023 After rst_i deasserts, still-high int_req_i lines SHALL be re-captured on the next edge.

Structure
REQ-024 Shared package int_ctrl_pkg SHALL hold the FSM state enum, MCAUSE_INT_MASK = 32'h8000_0000, and the 5-bit irq id type.
REQ-025 Single module, no sub-modules; pointer, pending, and FSM are in-module registers.

Verification
REQ-026 Line 3 high, mie_i = 32'h8, ptr = 0 -> int_o rises after 2+3+1 cycles; mcause_o = 32'h8000_0003.
REQ-027 Lines 1 and 2 high, mie_i = 32'h6 -> line 1 is served first; after int_rst_i, int_fin_o = 32'h2 for one cycle, then line 2 is served with mcause_o = 32'h8000_0002.
REQ-028 Line 5 high, mie_i = 0 -> int_o stays 0 for 100 cycles; setting mie_i = 32'h20 raises int_o.
REQ-029 Line 31 served, then int_rst_i -> ptr wraps to 0; line 0 pending is served next.
REQ-030 rst_i pulse while in BUSY -> int_o and mcause_o are 0 immediately; with int_req_i still high, the line is re-serviced after release.
REQ-031 int_req_i[4] held high through its own int_rst_i -> pending[4] remains 1 and line 4 is re-issued.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl_pkg
// Description : Shared types and constants for the round-robin interrupt
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    typedef logic [4:0] irq_id_t;

    localparam logic [31:0] MCAUSE_INT_MASK = 32'h8000_0000;

endpackage : int_ctrl_pkg
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller
// Description : Level-sensitive interrupt controller with a pending register
//               and a round-robin scan pointer; one interrupt in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller
    import int_ctrl_pkg::*;
#(
    parameter int N_IRQ = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] int_req_i,
    input  logic [31:0]      mie_i,
    input  logic             int_rst_i,
    output logic             int_o,
    output logic [31:0]      mcause_o,
    output logic [N_IRQ-1:0] int_fin_o
);

    localparam irq_id_t C_LAST_ID = irq_id_t'(N_IRQ - 1);

    state_t           r_state_q;
    state_t           w_state_d;
    irq_id_t          r_ptr_q;
    irq_id_t          w_ptr_d;
    irq_id_t          r_id_q;
    irq_id_t          w_id_d;
    logic [31:0]      r_mcause_q;
    logic [31:0]      w_mcause_d;
    logic [N_IRQ-1:0] r_pending_q;
    logic [N_IRQ-1:0] w_pending_d;

    logic [31:0]      w_elig;
    logic             w_any_elig;
    logic [N_IRQ-1:0] w_id_onehot;

    function automatic irq_id_t f_wrap_inc(input irq_id_t v);
        return (v == C_LAST_ID) ? irq_id_t'(0) : v + irq_id_t'(1);
    endfunction

    // Zero-extending pending to 32 bits lets the full mask be used and the
    // 5-bit pointer index every position without range concerns.
    assign w_elig      = 32'(r_pending_q) & mie_i;
    assign w_any_elig  = |w_elig;
    assign w_id_onehot = {{(N_IRQ-1){1'b0}}, 1'b1} << r_id_q;
    assign mcause_o    = r_mcause_q;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_q <= ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_any_elig) begin
                    w_state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!w_any_elig) begin
                    w_state_d = ST_IDLE;
                end else if (w_elig[r_ptr_q]) begin
                    w_state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (int_rst_i) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        int_o     = (r_state_q == ST_BUSY);
        int_fin_o = '0;
        if ((r_state_q == ST_BUSY) && int_rst_i) begin
            int_fin_o = w_id_onehot;
        end
    end

    // Datapath: pointer, serviced id, cause and pending lines
    always_comb begin
        w_ptr_d     = r_ptr_q;
        w_id_d      = r_id_q;
        w_mcause_d  = r_mcause_q;
        // A request still asserted on the completion edge re-arms its line.
        w_pending_d = (r_pending_q & ~int_fin_o) | int_req_i;
        case (r_state_q)
            ST_SCAN: begin
                if (w_any_elig) begin
                    if (w_elig[r_ptr_q]) begin
                        w_id_d     = r_ptr_q;
                        w_mcause_d = MCAUSE_INT_MASK | 32'(r_ptr_q);
                    end else begin
                        w_ptr_d = f_wrap_inc(r_ptr_q);
                    end
                end
            end
            ST_BUSY: begin
                if (int_rst_i) begin
                    w_ptr_d = f_wrap_inc(r_id_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr_q     <= '0;
            r_id_q      <= '0;
            r_mcause_q  <= '0;
            r_pending_q <= '0;
        end else begin
            r_ptr_q     <= w_ptr_d;
            r_id_q      <= w_id_d;
            r_mcause_q  <= w_mcause_d;
            r_pending_q <= w_pending_d;
        end
    end

endmodule : interrupt_controller
`default_nettype wire
